// File: rtl/mux_word_serializer.sv
// Serializes a 4-bit word through an external 4:1 mux: drives the word onto the
// mux inputs, steps the select lines 0..3 and samples mux_out after a settle time.
//
// state  | meaning
// IDLE   | waiting for a word; load_ready high
// SETTLE | select driven, counting down the settle time before sampling mux_out
// SHOW   | sampled bit presented on ser_bit, waiting for ser_ready
module mux_word_serializer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [3:0] load_data,
    output logic [3:0] mux_in,
    output logic       addr0,
    output logic       addr1,
    input  logic       mux_out,
    output logic       ser_bit,
    output logic       ser_valid,
    output logic       ser_last,
    input  logic       ser_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SHOW   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] count;

    assign load_ready = (state == IDLE);

    // Select lines come straight from the bit-index register.
    assign addr1 = idx[1];
    assign addr0 = idx[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            count     <= 4'd0;
            mux_in    <= 4'd0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid == 1'b1) begin
                        mux_in <= load_data;
                        idx    <= 2'd0;
                        count  <= SETTLE_INIT;
                        busy   <= 1'b1;
                        state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        ser_bit   <= mux_out;
                        ser_valid <= 1'b1;
                        ser_last  <= (idx == 2'd3);
                        state     <= SHOW;
                    end
                end
                SHOW: begin
                    if (ser_ready == 1'b1) begin
                        ser_valid <= 1'b0;
                        if (idx == 2'd3) begin
                            ser_last <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            idx   <= idx + 2'd1;
                            count <= SETTLE_INIT;
                            state <= SETTLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mux_word_serializer.md
Name: mux_word_serializer

Overview:
- Sequencing stage that wraps the 4:1 multiplexer (behavioral or structural).
- Upstream side: accepts a 4-bit word over a valid/ready handshake and drives the word onto the mux data inputs.
- Mux control: steps the mux select lines addr1:addr0 through 0..3 and samples the mux output after a programmable settle time.
- Downstream side: emits the selected bits as a serial stream with valid/ready/last. The settle time covers the gate delays of the structural mux.

Parameters:
SETTLE_CYCLES, 1, idle cycles between driving a new select and sampling mux_out; legal range 0..15.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  upstream word valid
load_ready  output  1  block can accept a word
load_data  input  4  word to serialize; bit i routed to mux input i
mux_in  output  4  registered word driving mux in0..in3 (bit i -> in_i)
addr0  output  1  mux select LSB
addr1  output  1  mux select MSB
mux_out  input  1  output of the external 4:1 mux
ser_bit  output  1  serial data bit
ser_valid  output  1  ser_bit valid
ser_last  output  1  marks 4th bit of a word
ser_ready  input  1  downstream accepts ser_bit
busy  output  1  word in progress

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, settle count=0. Outputs: mux_in=0, addr0=0, addr1=0, ser_bit=0, ser_valid=0, ser_last=0, busy=0, load_ready=1.
- Select mapping: addr1 = idx[1], addr0 = idx[0]. The mux selects in[2*addr1+addr0], so bit order is in0, in1, in2, in3 (load_data[0] first).
- All outputs are registered except load_ready. load_ready = (state==IDLE) and is combinational from state only.
- State IDLE:
  - load_ready=1, busy=0.
  - On load_valid at edge k: mux_in<=load_data, idx<=0, addr<=00, count<=SETTLE_CYCLES, busy<=1, go SETTLE.
- State SETTLE:
  - If count!=0: count decrements by 1 each edge.
  - When count==0 at an edge: ser_bit<=mux_out, ser_valid<=1, ser_last<=(idx==3), go SHOW.
  - Timing: for a load accepted at edge k, ser_valid is first high after edge k+SETTLE_CYCLES+1.
- State SHOW:
  - ser_bit and ser_last are held stable while ser_valid=1 and ser_ready=0. Backpressure is unbounded.
  - On edge with ser_ready=1 and idx==3: ser_valid<=0, ser_last<=0, busy<=0, go IDLE.
  - On edge with ser_ready=1 and idx<3: ser_valid<=0, idx<=idx+1, addr updated, count<=SETTLE_CYCLES, go SETTLE.
- Throughput:
  - With ser_ready tied high, each bit takes SETTLE_CYCLES+2 cycles.
  - A word takes 4*(SETTLE_CYCLES+2) cycles plus 1 IDLE cycle before the next accept. No same-cycle reload.
- mux_in holds the captured word for the entire word and retains it after completion until the next accept.
- addr holds the last select (11) after completion.
- load_valid while not IDLE is ignored and not queued; load_data may change freely while busy.
- ser_ready while ser_valid=0 is ignored.
- mux_out is sampled only on the SETTLE edge where count==0; glitches at other times have no effect.
- Reset mid-word: immediate return to reset values. The partial word is dropped and ser_valid drops asynchronously.
- X on load_data is never propagated into state. idx and count always reset cleanly.

Test Plan:
- Reset: assert rst_n=0 mid-simulation, then release -> all outputs at reset values, load_ready=1.
- Basic word: SETTLE_CYCLES=1, load 4'b1010, ser_ready=1.
  - Bits out are 0,1,0,1.
  - ser_last high only on the 4th bit.
  - First ser_valid 2 cycles after accept; bit period 3 cycles.
  - addr sequence 00,01,10,11.
  - Run with both behavioral and structural mux.
- Backpressure: load 4'b0110, hold ser_ready=0 for 5 cycles on bit 1 -> ser_bit=1 and ser_valid=1 stable for all 5 cycles, addr unchanged; sequence resumes correctly after release.
- Load while busy: pulse load_valid with 4'b1111 during word 4'b0001 -> output stays 1,0,0,0; the second word is never emitted; load_ready=0 throughout.
- Reset mid-word: drop rst_n during bit 2 of 4'b1011 -> ser_valid=0 and mux_in=0 immediately; next load 4'b0100 serializes 0,0,1,0 from idx 0.
- SETTLE_CYCLES=0, back-to-back loads 4'b1100 then 4'b0011, load_valid held high -> bit period 2 cycles; second word accepted exactly 1 cycle after the final handshake; output 0,0,1,1,1,1,0,0.
